// File: rtl/sdm_alloc_pkg.sv
// Shared types and helpers for the SDM allocation controller.
package sdm_alloc_pkg;

  // Widest configuration column the one-hot checker accepts.
  localparam int unsigned ONEHOT_MAX_W = 32;

  // Per-client request FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    GRANT = 2'd2,
    REL   = 2'd3
  } alloc_state_e;

  // Returns 1 when exactly one bit of v is set.
  function automatic logic onehot_chk(input logic [ONEHOT_MAX_W-1:0] v);
    return (v != '0) && ((v & (v - ONEHOT_MAX_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/sdm_req_fsm.sv
// One client's request/release FSM with its acknowledge synchroniser
// and its latched crossbar select.
module sdm_req_fsm
  import sdm_alloc_pkg::*;
#(
  parameter int M           = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pkt_vld,
  input  logic         flit_vld,
  input  logic         flit_tail,
  input  logic [M-1:0] out_rdy,
  input  logic         ca_async,
  input  logic [M-1:0] cfg_col,
  output logic         flit_rdy,
  output logic         arb_c,
  output logic [M-1:0] xb_sel,
  output logic         xb_vld,
  output logic         cfg_err
);

  logic [SYNC_STAGES-1:0] ca_sync_q;
  logic [SYNC_STAGES-1:0] ca_sync_d;
  logic                   ca_s;

  alloc_state_e state_q;
  alloc_state_e state_d;
  logic         arb_c_q;
  logic         arb_c_d;
  logic [M-1:0] xb_sel_q;
  logic [M-1:0] xb_sel_d;
  logic         xb_vld_q;
  logic         xb_vld_d;
  logic         cfg_err_q;
  logic         cfg_err_d;
  logic         xfer;

  // Shift the asynchronous acknowledge one stage deeper each cycle.
  always_comb begin
    ca_sync_d = {ca_sync_q[SYNC_STAGES-2:0], ca_async};
  end

  assign ca_s = ca_sync_q[SYNC_STAGES-1];

  // Synchroniser flops; cleared so a stale ack cannot survive reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ca_sync_q <= '0;
    end else begin
      ca_sync_q <= ca_sync_d;
    end
  end

  // xb_vld is only ever set in GRANT, so it alone gates the transfer.
  assign xfer = flit_vld & xb_vld_q & (|(xb_sel_q & out_rdy));

  // Next-state and next-output decode for the 4-phase handshake.
  always_comb begin
    state_d   = state_q;
    arb_c_d   = arb_c_q;
    xb_sel_d  = xb_sel_q;
    xb_vld_d  = xb_vld_q;
    cfg_err_d = cfg_err_q;
    case (state_q)
      IDLE: begin
        // Wait for the previous ack to fall before raising a new request.
        if (pkt_vld && !ca_s) begin
          state_d = REQ;
          arb_c_d = 1'b1;
        end
      end
      REQ: begin
        // Request is held even if pkt_vld drops, keeping the handshake legal.
        arb_c_d = 1'b1;
        if (ca_s) begin
          if (onehot_chk(ONEHOT_MAX_W'(cfg_col))) begin
            state_d  = GRANT;
            xb_sel_d = cfg_col;
            xb_vld_d = 1'b1;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      GRANT: begin
        if (xfer && flit_tail) begin
          state_d  = REL;
          arb_c_d  = 1'b0;
          xb_vld_d = 1'b0;
          xb_sel_d = '0;
        end
      end
      REL: begin
        if (!ca_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d  = IDLE;
        arb_c_d  = 1'b0;
        xb_vld_d = 1'b0;
        xb_sel_d = '0;
      end
    endcase
  end

  // FSM state and registered outputs; reset drops the request at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      arb_c_q   <= 1'b0;
      xb_sel_q  <= '0;
      xb_vld_q  <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      arb_c_q   <= arb_c_d;
      xb_sel_q  <= xb_sel_d;
      xb_vld_q  <= xb_vld_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign flit_rdy = xfer;
  assign arb_c    = arb_c_q;
  assign xb_sel   = xb_sel_q;
  assign xb_vld   = xb_vld_q;
  assign cfg_err  = cfg_err_q;

endmodule

// File: rtl/sdm_alloc_ctl.sv
// Request/release controller in front of the SDM match arbiter: one
// request FSM per client, column extraction from the match matrix and
// a combined sticky configuration error.
module sdm_alloc_ctl
  import sdm_alloc_pkg::*;
#(
  parameter int N           = 2,
  parameter int M           = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   pkt_vld,
  input  logic [N-1:0]   flit_vld,
  input  logic [N-1:0]   flit_tail,
  output logic [N-1:0]   flit_rdy,
  input  logic [M-1:0]   out_rdy,
  output logic [N-1:0]   arb_c,
  input  logic [N-1:0]   arb_ca,
  input  logic [M*N-1:0] arb_cfg,
  output logic [N*M-1:0] xb_sel,
  output logic [N-1:0]   xb_vld,
  output logic           cfg_err
);

  // Column j of the match matrix: which resources are matched to client j.
  logic [N-1:0][M-1:0] cfg_col;
  logic [N-1:0]        err_vec;

  for (genvar j = 0; j < N; j++) begin : g_col
    for (genvar i = 0; i < M; i++) begin : g_bit
      assign cfg_col[j][i] = arb_cfg[i*N+j];
    end
  end

  for (genvar j = 0; j < N; j++) begin : g_client
    sdm_req_fsm #(
      .M           (M),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_fsm (
      .clk       (clk),
      .rst       (rst),
      .pkt_vld   (pkt_vld[j]),
      .flit_vld  (flit_vld[j]),
      .flit_tail (flit_tail[j]),
      .out_rdy   (out_rdy),
      .ca_async  (arb_ca[j]),
      .cfg_col   (cfg_col[j]),
      .flit_rdy  (flit_rdy[j]),
      .arb_c     (arb_c[j]),
      .xb_sel    (xb_sel[j*M +: M]),
      .xb_vld    (xb_vld[j]),
      .cfg_err   (err_vec[j])
    );
  end

  assign cfg_err = |err_vec;

endmodule

// File: tb/tb_sdm_alloc_ctl.sv
// Directed bench for sdm_alloc_ctl (N=M=2, SYNC_STAGES=2) with a
// behavioural 1-cycle-ack arbiter and a per-client flit scoreboard.
module tb_sdm_alloc_ctl;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] pkt_vld;
  logic [1:0] flit_vld;
  logic [1:0] flit_tail;
  logic [1:0] flit_rdy;
  logic [1:0] out_rdy;
  logic [1:0] arb_c;
  logic [1:0] arb_ca;
  logic [3:0] arb_cfg;
  logic [3:0] xb_sel;
  logic [1:0] xb_vld;
  logic       cfg_err;

  int nerr = 0;
  int nchk = 0;
  int rem[2];
  int nrdy[2];
  int ca_hold[2];
  logic [1:0] q0[$];
  logic [1:0] q1[$];

  sdm_alloc_ctl #(.N(2), .M(2), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .pkt_vld   (pkt_vld),
    .flit_vld  (flit_vld),
    .flit_tail (flit_tail),
    .flit_rdy  (flit_rdy),
    .out_rdy   (out_rdy),
    .arb_c     (arb_c),
    .arb_ca    (arb_ca),
    .arb_cfg   (arb_cfg),
    .xb_sel    (xb_sel),
    .xb_vld    (xb_vld),
    .cfg_err   (cfg_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int j = 0; j < 2; j++) begin
      flit_vld[j]  = (rem[j] > 0);
      flit_tail[j] = (rem[j] == 1);
    end
  endtask

  task automatic push_pkt(input int j, input logic [1:0] sel, input int nflit);
    for (int k = 0; k < nflit; k++) begin
      if (j == 0) q0.push_back(sel);
      else q1.push_back(sel);
    end
  endtask

  // One clock: score transfers at negedge, then update arbiter and driver.
  task automatic cyc();
    logic [1:0] e;
    @(negedge clk);
    for (int j = 0; j < 2; j++) begin
      if (flit_rdy[j]) begin
        if ((j == 0 ? q0.size() : q1.size()) == 0) begin
          chk($sformatf("unexpected_flit%0d", j), 32'(flit_rdy[j]), 32'd0);
        end else begin
          if (j == 0) e = q0.pop_front();
          else e = q1.pop_front();
          chk($sformatf("flit_sel%0d", j), 32'(xb_sel[j*2 +: 2]), 32'(e));
          rem[j]--;
          nrdy[j]++;
        end
      end
    end
    @(posedge clk);
    #1;
    for (int j = 0; j < 2; j++) begin
      if (ca_hold[j] > 0) begin
        arb_ca[j] = 1'b1;
        ca_hold[j]--;
      end else begin
        arb_ca[j] = arb_c[j];
      end
    end
    drive();
  endtask

  task automatic cycn(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  initial begin
    rst = 1'b1;
    pkt_vld = '0; flit_vld = '0; flit_tail = '0;
    out_rdy = 2'b11; arb_ca = '0; arb_cfg = '0;
    for (int j = 0; j < 2; j++) begin rem[j] = 0; nrdy[j] = 0; ca_hold[j] = 0; end

    // Reset state
    cycn(2);
    chk("rst_arb_c", 32'(arb_c), 32'd0);
    chk("rst_xb_sel", 32'(xb_sel), 32'd0);
    chk("rst_xb_vld", 32'(xb_vld), 32'd0);
    chk("rst_flit_rdy", 32'(flit_rdy), 32'd0);
    chk("rst_cfg_err", 32'(cfg_err), 32'd0);
    rst = 1'b0;

    // 1: client0 3-flit packet, res0
    arb_cfg = 4'b0001; pkt_vld[0] = 1'b1; rem[0] = 3; push_pkt(0, 2'b01, 3); drive();
    chk("t1_c_before", 32'(arb_c[0]), 32'd0);
    cyc();
    chk("t1_c_rise", 32'(arb_c[0]), 32'd1);
    cycn(2);
    chk("t1_vld_early", 32'(xb_vld[0]), 32'd0);
    cyc();
    chk("t1_sel", 32'(xb_sel[1:0]), 32'd1);
    chk("t1_vld", 32'(xb_vld[0]), 32'd1);
    pkt_vld[0] = 1'b0;
    cycn(2);
    chk("t1_c_hold", 32'(arb_c[0]), 32'd1);
    cyc();
    chk("t1_c_fall", 32'(arb_c[0]), 32'd0);
    chk("t1_nrdy", 32'(nrdy[0]), 32'd3);
    chk("t1_vld_clr", 32'(xb_vld[0]), 32'd0);
    chk("t1_sel_clr", 32'(xb_sel[1:0]), 32'd0);
    cycn(5);

    // 2: both clients together, cfg 1001
    arb_cfg = 4'b1001; pkt_vld = 2'b11; rem[0] = 2; rem[1] = 3;
    push_pkt(0, 2'b01, 2); push_pkt(1, 2'b10, 3); drive();
    cyc();
    chk("t2_c_rise", 32'(arb_c), 32'd3);
    cycn(3);
    chk("t2_sel", 32'(xb_sel), 32'h9);
    chk("t2_vld", 32'(xb_vld), 32'd3);
    pkt_vld = 2'b00;
    cycn(2);
    chk("t2_c_rel0", 32'(arb_c), 32'd2);
    cyc();
    chk("t2_c_rel1", 32'(arb_c), 32'd0);
    chk("t2_nrdy1", 32'(nrdy[1]), 32'd3);
    cycn(5);

    // 3: client0 granted res1 while res1 stalled
    arb_cfg = 4'b0100; out_rdy = 2'b01; pkt_vld[0] = 1'b1; rem[0] = 2;
    push_pkt(0, 2'b10, 2); drive();
    cycn(4);
    chk("t3_sel", 32'(xb_sel[1:0]), 32'd2);
    pkt_vld[0] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("t3_stall", 32'(flit_rdy[0]), 32'd0);
      cyc();
    end
    out_rdy = 2'b11;
    #1;
    chk("t3_rdy_rise", 32'(flit_rdy[0]), 32'd1);
    cycn(2);
    chk("t3_c_fall", 32'(arb_c[0]), 32'd0);
    cycn(5);

    // 4: single-flit packet, ack held high after release
    arb_cfg = 4'b0001; pkt_vld[0] = 1'b1; rem[0] = 1; push_pkt(0, 2'b01, 1); drive();
    cycn(4);
    chk("t4_rdy_first", 32'(flit_rdy[0]), 32'd1);
    ca_hold[0] = 4;
    cyc();
    chk("t4_rel", 32'(arb_c[0]), 32'd0);
    rem[0] = 1; push_pkt(0, 2'b01, 1); drive();
    for (int k = 0; k < 7; k++) begin
      cyc();
      chk("t4_no_rise", 32'(arb_c[0]), 32'd0);
    end
    cyc();
    chk("t4_rise", 32'(arb_c[0]), 32'd1);
    cycn(3);
    chk("t4_vld2", 32'(xb_vld[0]), 32'd1);
    pkt_vld[0] = 1'b0;
    cyc();
    chk("t4_c_fall2", 32'(arb_c[0]), 32'd0);
    cycn(5);

    // 5: non-one-hot column 0
    arb_cfg = 4'b0101; pkt_vld[0] = 1'b1; rem[0] = 3; push_pkt(0, 2'b01, 3); drive();
    chk("t5_err_before", 32'(cfg_err), 32'd0);
    cycn(4);
    chk("t5_err", 32'(cfg_err), 32'd1);
    chk("t5_vld", 32'(xb_vld[0]), 32'd0);
    chk("t5_c_req", 32'(arb_c[0]), 32'd1);
    chk("t5_rdy", 32'(flit_rdy[0]), 32'd0);
    cycn(3);
    chk("t5_err_sticky", 32'(cfg_err), 32'd1);
    chk("t5_vld_still", 32'(xb_vld[0]), 32'd0);
    arb_cfg = 4'b0001;
    cyc();
    chk("t5_grant", 32'(xb_vld[0]), 32'd1);
    chk("t5_err_kept", 32'(cfg_err), 32'd1);
    pkt_vld[0] = 1'b0;
    cyc();

    // 6: reset mid-packet in GRANT
    rst = 1'b1;
    #1;
    chk("t6_arb_c", 32'(arb_c), 32'd0);
    chk("t6_xb_vld", 32'(xb_vld), 32'd0);
    chk("t6_xb_sel", 32'(xb_sel), 32'd0);
    chk("t6_flit_rdy", 32'(flit_rdy), 32'd0);
    chk("t6_cfg_err", 32'(cfg_err), 32'd0);
    q0.delete(); rem[0] = 0; pkt_vld = '0; arb_ca = '0; drive();
    cycn(2);
    rst = 1'b0;
    pkt_vld[0] = 1'b1; rem[0] = 1; push_pkt(0, 2'b01, 1); drive();
    chk("t6_c_idle", 32'(arb_c[0]), 32'd0);
    cyc();
    chk("t6_c_rise", 32'(arb_c[0]), 32'd1);
    cycn(3);
    chk("t6_vld", 32'(xb_vld[0]), 32'd1);
    pkt_vld[0] = 1'b0;
    cyc();
    chk("t6_c_fall", 32'(arb_c[0]), 32'd0);
    cycn(5);

    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/sdm_alloc_ctl.md
Name: sdm_alloc_ctl

Overview:
- Synchronous request/release controller that sits directly upstream of the multi-resource match arbiter in the SDM router.
- Drives the arbiter's per-client 4-phase request wires (c) and consumes its acknowledgements (ca) and configuration matrix (cfg).
- Latches each client's granted sub-channel and gates flit transfer across the crossbar until the packet tail passes.
- Returns the arbiter request to zero, and waits for the acknowledgement to fall, before accepting the next packet.

Parameters:
- N, 2, number of clients (input sub-channels).
- M, 2, number of resources (output sub-channels).
- SYNC_STAGES, 2, flip-flop depth of the ca synchroniser (legal values ≥2).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- pkt_vld  in  N  client j holds a packet head waiting for allocation.
- flit_vld  in  N  client j flit valid.
- flit_tail  in  N  client j flit is the packet tail.
- flit_rdy  out  N  client j flit accepted this cycle.
- out_rdy  in  M  output sub-channel i can accept a flit.
- arb_c  out  N  4-phase request to arbiter client j (registered).
- arb_ca  in  N  arbiter acknowledge; asynchronous to clk.
- arb_cfg  in  M*N  arbiter match matrix; bit [i*N+j] means resource i is matched to client j.
- xb_sel  out  N*M  registered one-hot crossbar select; bits [j*M +: M] belong to client j.
- xb_vld  out  N  client j holds a valid selection.
- cfg_err  out  1  sticky flag: an acknowledged configuration column was not one-hot.

Behaviour:
- Reset (asynchronous, immediate):
  - arb_c, flit_rdy, xb_sel, xb_vld and cfg_err all go to 0.
  - Every FSM goes to IDLE and the synchroniser flops clear.
- Synchroniser: arb_ca passes through SYNC_STAGES flops to give ca_s[j].
  - arb_cfg is sampled only while ca_s[j]=1. It is quasi-static by then, because the arbiter holds cfg stable while ca is high.
- Per-client FSM, N independent instances. States: IDLE, REQ, GRANT, REL.
  - IDLE: if pkt_vld[j] and ca_s[j]=0, go to REQ; arb_c[j] is 1 from the next cycle.
  - REQ: arb_c[j]=1. When ca_s[j]=1, take column j of arb_cfg (M bits).
    - One-hot column: register it into xb_sel[j], set xb_vld[j], go to GRANT.
    - Column not one-hot: set cfg_err and stay in REQ; cfg_err clears only on reset.
  - GRANT: flit_rdy[j] = flit_vld[j] & |(xb_sel[j] & out_rdy), combinational from registered state.
    - A transfer with flit_tail[j]=1 moves the FSM to REL.
    - On the next edge, arb_c[j] and xb_vld[j] clear; xb_sel[j] clears to 0.
  - REL: arb_c[j]=0; flit_rdy[j]=0. When ca_s[j]=0, go to IDLE.
- Latency, arbiter acknowledging instantly:
  - pkt_vld to arb_c rise: 1 cycle.
  - arb_ca rise to GRANT: SYNC_STAGES+1 cycles.
  - Tail transfer to arb_c fall: 1 cycle.
- Single-flit packet (head = tail): transfers in the first GRANT cycle, then goes to REL.
- pkt_vld dropping while in REQ is illegal. The request is held anyway, preserving 4-phase correctness.
- Two clients acknowledged on the same cycle are handled independently. Distinct resources are guaranteed by the arbiter and are not rechecked.
- An arbiter ack that never arrives leaves the FSM in REQ indefinitely; there is no timeout.
- Reset mid-packet drops arb_c asynchronously. The arbiter then releases through its own return-to-zero.

Decomposition:
- Shared package sdm_alloc_pkg:
  - state enum {IDLE, REQ, GRANT, REL} (2-bit);
  - function onehot_chk(M-bit) returning 1 for exactly one bit set.
- Sub-module sdm_req_fsm: one client's FSM, its ca synchroniser and its xb_sel register, instanced N times.
- Top level: sdm_alloc_ctl extracts columns from arb_cfg, ORs the per-client error flags and maps the ports.

Test Plan:
- N=M=2, behavioural arbiter with 1-cycle ack. Client0 sends a 3-flit packet with out_rdy=11.
  - Expect arb_c[0]=1 one cycle after pkt_vld.
  - Expect xb_sel[0]=01 and xb_vld[0]=1 three cycles after ca.
  - Expect 3 flit_rdy pulses, then arb_c[0]=0 one cycle after the tail.
- Both clients request together; arbiter grants cfg=0b1001 (client0→res0, client1→res1).
  - Expect xb_sel = {10, 01}; both transfer concurrently; each releases independently.
- Client0 granted res1 with out_rdy[1]=0 for 5 cycles.
  - Expect flit_rdy[0]=0 throughout; it rises on the cycle out_rdy[1]=1.
- Single-flit packet: tail accepted in the first GRANT cycle; REL is entered.
  - Arbiter keeps ca high for 4 cycles with pkt_vld still high. Expect no new arb_c rise until ca_s=0.
- Arbiter presents column 0 = 11 with ca[0]=1.
  - Expect cfg_err=1, FSM stays in REQ and xb_vld[0]=0. cfg_err stays set until rst.
- Assert rst during GRANT mid-packet.
  - Expect arb_c, xb_vld, xb_sel and flit_rdy at 0 immediately (before the next clk edge). FSM in IDLE after reset release.
